adc_channel_stats: RTL and testbench

// Downstream consumer of the XADC sampler's per-channel 12-bit results and update strobes.

---
 rtl/adc_channel_stats.sv | 175 +++++++++++++++++
 tb/tb_adc_channel_stats.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adc_channel_stats.sv
// rtl/adc_channel_stats.sv - per-channel ADC sample count/sum/min/max with snapshot shadow set
module adc_channel_stats #(
  parameter int NUM_CHANNELS = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CHANNELS*12-1:0] analog_meas,
  input  logic [NUM_CHANNELS-1:0]   meas_updated,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      snapshot,
  output logic                      snapshot_done,
  output logic [7:0]                snapshot_seq,
  input  logic [3:0]                rd_sel,
  output logic [COUNT_WIDTH-1:0]    rd_count,
  output logic [COUNT_WIDTH+11:0]   rd_sum,
  output logic [11:0]               rd_min,
  output logic [11:0]               rd_max,
  output logic                      rd_sat
);

  localparam int SUM_WIDTH = COUNT_WIDTH + 12;

  typedef enum logic {ST_IDLE, ST_COPY} state_t;
  state_t r_state;

  logic [COUNT_WIDTH-1:0] r_cnt    [NUM_CHANNELS];
  logic [SUM_WIDTH-1:0]   r_sum    [NUM_CHANNELS];
  logic [11:0]            r_min    [NUM_CHANNELS];
  logic [11:0]            r_max    [NUM_CHANNELS];
  logic                   r_sat    [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] r_sh_cnt [NUM_CHANNELS];
  logic [SUM_WIDTH-1:0]   r_sh_sum [NUM_CHANNELS];
  logic [11:0]            r_sh_min [NUM_CHANNELS];
  logic [11:0]            r_sh_max [NUM_CHANNELS];
  logic                   r_sh_sat [NUM_CHANNELS];

  logic [COUNT_WIDTH-1:0] w_sh_cnt [NUM_CHANNELS];
  logic [SUM_WIDTH-1:0]   w_sh_sum [NUM_CHANNELS];
  logic [11:0]            w_sh_min [NUM_CHANNELS];
  logic [11:0]            w_sh_max [NUM_CHANNELS];
  logic                   w_sh_sat [NUM_CHANNELS];

  logic [COUNT_WIDTH-1:0] w_rd_cnt;
  logic [SUM_WIDTH-1:0]   w_rd_sum;
  logic [11:0]            w_rd_min;
  logic [11:0]            w_rd_max;
  logic                   w_rd_sat;
  logic                   w_snap_go;

  assign w_snap_go = snapshot & ~clear & (r_state == ST_IDLE);

  // Next shadow state; readout registers this so a capture shows up alongside snapshot_done.
  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      w_sh_cnt[k] = r_sh_cnt[k];
      w_sh_sum[k] = r_sh_sum[k];
      w_sh_min[k] = r_sh_min[k];
      w_sh_max[k] = r_sh_max[k];
      w_sh_sat[k] = r_sh_sat[k];
      if (clear) begin
        w_sh_cnt[k] = '0;
        w_sh_sum[k] = '0;
        w_sh_min[k] = 12'hFFF;
        w_sh_max[k] = 12'h000;
        w_sh_sat[k] = 1'b0;
      end else if (w_snap_go) begin
        w_sh_cnt[k] = r_cnt[k];
        w_sh_sum[k] = r_sum[k];
        w_sh_min[k] = r_min[k];
        w_sh_max[k] = r_max[k];
        w_sh_sat[k] = r_sat[k];
      end
    end
  end

  always_comb begin
    w_rd_cnt = '0;
    w_rd_sum = '0;
    w_rd_min = 12'hFFF;
    w_rd_max = 12'h000;
    w_rd_sat = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (rd_sel == 4'(k)) begin
        w_rd_cnt = w_sh_cnt[k];
        w_rd_sum = w_sh_sum[k];
        w_rd_min = w_sh_min[k];
        w_rd_max = w_sh_max[k];
        w_rd_sat = w_sh_sat[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      snapshot_done <= 1'b0;
      snapshot_seq  <= 8'd0;
      rd_count      <= '0;
      rd_sum        <= '0;
      rd_min        <= 12'hFFF;
      rd_max        <= 12'h000;
      rd_sat        <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_cnt[k]    <= '0;
        r_sum[k]    <= '0;
        r_min[k]    <= 12'hFFF;
        r_max[k]    <= 12'h000;
        r_sat[k]    <= 1'b0;
        r_sh_cnt[k] <= '0;
        r_sh_sum[k] <= '0;
        r_sh_min[k] <= 12'hFFF;
        r_sh_max[k] <= 12'h000;
        r_sh_sat[k] <= 1'b0;
      end
    end else begin
      snapshot_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_snap_go) begin
          r_state       <= ST_COPY;
          snapshot_done <= 1'b1;
          snapshot_seq  <= snapshot_seq + 8'd1;
        end
        ST_COPY: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      rd_count <= w_rd_cnt;
      rd_sum   <= w_rd_sum;
      rd_min   <= w_rd_min;
      rd_max   <= w_rd_max;
      rd_sat   <= w_rd_sat;

      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_sh_cnt[k] <= w_sh_cnt[k];
        r_sh_sum[k] <= w_sh_sum[k];
        r_sh_min[k] <= w_sh_min[k];
        r_sh_max[k] <= w_sh_max[k];
        r_sh_sat[k] <= w_sh_sat[k];
        if (clear) begin
          r_cnt[k] <= '0;
          r_sum[k] <= '0;
          r_min[k] <= 12'hFFF;
          r_max[k] <= 12'h000;
          r_sat[k] <= 1'b0;
        end else if (w_snap_go) begin
          // A sample strobed on the capture edge opens the new window.
          r_sat[k] <= 1'b0;
          if (enable && meas_updated[k]) begin
            r_cnt[k] <= COUNT_WIDTH'(1);
            r_sum[k] <= SUM_WIDTH'(analog_meas[12*k +: 12]);
            r_min[k] <= analog_meas[12*k +: 12];
            r_max[k] <= analog_meas[12*k +: 12];
          end else begin
            r_cnt[k] <= '0;
            r_sum[k] <= '0;
            r_min[k] <= 12'hFFF;
            r_max[k] <= 12'h000;
          end
        end else if (enable && meas_updated[k]) begin
          if (&r_cnt[k]) begin
            r_sat[k] <= 1'b1;
          end else begin
            r_cnt[k] <= r_cnt[k] + COUNT_WIDTH'(1);
            r_sum[k] <= r_sum[k] + SUM_WIDTH'(analog_meas[12*k +: 12]);
            if (analog_meas[12*k +: 12] < r_min[k]) r_min[k] <= analog_meas[12*k +: 12];
            if (analog_meas[12*k +: 12] > r_max[k]) r_max[k] <= analog_meas[12*k +: 12];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_channel_stats.sv
// tb/tb_adc_channel_stats.sv - directed-vector bench for adc_channel_stats (2 channels, 4-bit count)
module tb_adc_channel_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] analog_meas;
  logic [1:0]  meas_updated;
  logic        enable;
  logic        clear;
  logic        snapshot;
  logic        snapshot_done;
  logic [7:0]  snapshot_seq;
  logic [3:0]  rd_sel;
  logic [3:0]  rd_count;
  logic [15:0] rd_sum;
  logic [11:0] rd_min;
  logic [11:0] rd_max;
  logic        rd_sat;

  int n_cmp = 0;
  int n_err = 0;

  adc_channel_stats #(.NUM_CHANNELS(2), .COUNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .analog_meas(analog_meas), .meas_updated(meas_updated),
    .enable(enable), .clear(clear), .snapshot(snapshot), .snapshot_done(snapshot_done),
    .snapshot_seq(snapshot_seq), .rd_sel(rd_sel), .rd_count(rd_count), .rd_sum(rd_sum),
    .rd_min(rd_min), .rd_max(rd_max), .rd_sat(rd_sat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] mask, input logic [11:0] v0, input logic [11:0] v1);
    meas_updated = mask;
    analog_meas  = {v1, v0};
    step();
    meas_updated = 2'b00;
  endtask

  task automatic do_snap();
    snapshot = 1'b1;
    step();
    snapshot = 1'b0;
  endtask

  task automatic check_rd(input string tag, input int cnt, input int sum,
                          input int mn, input int mx, input int sat);
    check_eq({tag, ".count"}, 32'(rd_count), 32'(cnt));
    check_eq({tag, ".sum"},   32'(rd_sum),   32'(sum));
    check_eq({tag, ".min"},   32'(rd_min),   32'(mn));
    check_eq({tag, ".max"},   32'(rd_max),   32'(mx));
    check_eq({tag, ".sat"},   32'(rd_sat),   32'(sat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; analog_meas = '0; meas_updated = '0; enable = 1'b1;
    clear = 1'b0; snapshot = 1'b0; rd_sel = 4'd0;
    step(); step();
    rst = 1'b0;
    check_rd("reset", 0, 0, 12'hFFF, 0, 0);
    check_eq("reset.seq", 32'(snapshot_seq), 0);
    check_eq("reset.done", 32'(snapshot_done), 0);

    // ch0: 100, 300, 200
    strobe(2'b01, 12'd100, 12'd0);
    strobe(2'b01, 12'd300, 12'd0);
    strobe(2'b01, 12'd200, 12'd0);
    do_snap();
    check_eq("t1.done", 32'(snapshot_done), 1);
    check_eq("t1.seq", 32'(snapshot_seq), 1);
    check_rd("t1", 3, 600, 100, 300, 0);
    step();
    check_eq("t1.done_low", 32'(snapshot_done), 0);

    // both channels together x4
    for (int i = 0; i < 4; i++) strobe(2'b11, 12'd5, 12'd4095);
    do_snap();
    check_rd("t2.ch0", 4, 20, 5, 5, 0);
    rd_sel = 4'd1;
    step();
    check_rd("t2.ch1", 4, 16380, 4095, 4095, 0);
    check_eq("t2.seq", 32'(snapshot_seq), 2);
    rd_sel = 4'd0;

    // saturation at count=15
    for (int i = 0; i < 17; i++) strobe(2'b01, 12'd1, 12'd0);
    do_snap();
    check_rd("t3.sat", 15, 15, 1, 1, 1);
    step();
    do_snap();
    check_rd("t3.after", 0, 0, 12'hFFF, 0, 0);
    check_eq("t3.seq", 32'(snapshot_seq), 4);
    step();

    // sample on the capture edge
    strobe(2'b01, 12'd3, 12'd0);
    meas_updated = 2'b01; analog_meas = {12'd0, 12'd7};
    do_snap();
    meas_updated = 2'b00;
    check_rd("t4.excl", 1, 3, 3, 3, 0);
    step();
    do_snap();
    check_rd("t4.next", 1, 7, 7, 7, 0);
    check_eq("t4.seq", 32'(snapshot_seq), 6);
    step();

    // back-to-back snapshot pulses
    strobe(2'b01, 12'd9, 12'd0);
    snapshot = 1'b1;
    step();
    check_eq("b2b.done1", 32'(snapshot_done), 1);
    check_eq("b2b.seq1", 32'(snapshot_seq), 7);
    step();
    snapshot = 1'b0;
    check_eq("b2b.done2", 32'(snapshot_done), 0);
    check_eq("b2b.seq2", 32'(snapshot_seq), 7);
    check_rd("b2b.keep", 1, 9, 9, 9, 0);
    step();

    // clear together with snapshot
    strobe(2'b01, 12'd50, 12'd0);
    clear = 1'b1; snapshot = 1'b1;
    step();
    clear = 1'b0; snapshot = 1'b0;
    check_eq("clr.done", 32'(snapshot_done), 0);
    check_eq("clr.seq", 32'(snapshot_seq), 7);
    check_rd("clr.shadow", 0, 0, 12'hFFF, 0, 0);
    do_snap();
    check_rd("clr.live", 0, 0, 12'hFFF, 0, 0);
    check_eq("clr.seq2", 32'(snapshot_seq), 8);
    step();

    // enable=0 ignores strobes
    enable = 1'b0;
    strobe(2'b11, 12'd10, 12'd20);
    enable = 1'b1;
    do_snap();
    check_rd("en0", 0, 0, 12'hFFF, 0, 0);
    step();

    // out-of-range rd_sel and mid-window reset
    for (int i = 0; i < 9; i++) strobe(2'b01, 12'd2, 12'd0);
    do_snap();
    check_rd("rst.pre", 9, 18, 2, 2, 0);
    rd_sel = 4'd2;
    step();
    check_rd("sel2", 0, 0, 12'hFFF, 0, 0);
    rd_sel = 4'd15;
    step();
    check_rd("sel15", 0, 0, 12'hFFF, 0, 0);
    rd_sel = 4'd0;
    step();
    check_rd("rst.back", 9, 18, 2, 2, 0);
    for (int i = 0; i < 9; i++) strobe(2'b01, 12'd4, 12'd0);
    snapshot = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0; snapshot = 1'b0;
    check_rd("rst", 0, 0, 12'hFFF, 0, 0);
    check_eq("rst.seq", 32'(snapshot_seq), 0);
    check_eq("rst.done", 32'(snapshot_done), 0);
    do_snap();
    check_rd("rst.live", 0, 0, 12'hFFF, 0, 0);
    check_eq("rst.seq2", 32'(snapshot_seq), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
